// File: rtl/hex_display_sequencer.sv
// Seven-segment bank controller: per-digit value/blank storage, one shared hex decoder
// swept across the digits one per clock, with a registered segment pattern per digit.

module hex_decoder (
  input  logic [3:0] value,
  output logic [6:0] seg_c
);
  // Active-low segments, bit order g..a
  always_comb begin
    seg_c = 7'h7F;
    unique case (value)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end
endmodule

module hex_display_sequencer #(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DIV_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2:0]              wr_digit,
  input  logic [3:0]              wr_value,
  input  logic                    wr_blank,
  input  logic                    refresh_req,
  output logic                    busy,
  output logic [7*NUM_DIGITS-1:0] hex_out
);
  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [DIV_W-1:0] div_q;
  logic             pending, pending_n;
  logic             tick_pend, tick_pend_n;
  logic [3:0]       value_q [NUM_DIGITS];
  logic             blank_q [NUM_DIGITS];
  logic [6:0]       dec_c;
  logic             wrap_c;
  logic             wr_commit_c;

  assign wr_ready    = (state == IDLE);
  assign busy        = (state == SCAN);
  assign wrap_c      = (div_q == DIV_LAST);
  assign wr_commit_c = wr_valid && wr_ready && (32'(wr_digit) < NUM_DIGITS);

  // Free-running refresh divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_q <= '0;
    else if (wrap_c) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      tick_pend <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      pending   <= pending_n;
      tick_pend <= tick_pend_n;
    end
  end

  // Requests accumulate until a sweep starts; entering SCAN absorbs everything seen so far
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    pending_n   = pending | wr_commit_c;
    tick_pend_n = tick_pend | wrap_c | refresh_req;
    unique case (state)
      IDLE: begin
        if (pending || tick_pend || refresh_req) begin
          state_n     = SCAN;
          idx_n       = '0;
          pending_n   = 1'b0;
          tick_pend_n = 1'b0;
        end
      end
      SCAN: begin
        if (idx == LAST_IDX) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Digit storage; out-of-range indices are acknowledged but dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        value_q[k] <= 4'h0;
        blank_q[k] <= 1'b1;
      end
    end else if (wr_commit_c) begin
      value_q[wr_digit] <= wr_value;
      blank_q[wr_digit] <= wr_blank;
    end
  end

  hex_decoder u_dec (
    .value (value_q[idx]),
    .seg_c (dec_c)
  );

  // Only the digit under the sweep pointer loads; the others hold
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [6:0] seg_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        seg_q <= 7'h7F;
      end else if (state == SCAN && idx == IDX_W'(k)) begin
        seg_q <= blank_q[k] ? 7'h7F : dec_c;
      end
    end
    assign hex_out[7*k +: 7] = seg_q;
  end
endmodule

// File: tb/tb_hex_display_sequencer.sv
// Bench for hex_display_sequencer: directed scenarios plus a cycle model that predicts
// busy, wr_ready and every segment pattern from the sweep/request rules.

module tb_hex_display_sequencer;
  localparam int unsigned N  = 6;
  localparam int          R  = 200;
  localparam logic [7*N-1:0] ALL_OFF = '1;
  localparam logic [7*N-1:0] HEX_ONE8 = {7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h7F, 7'h7F};
  localparam logic [7*N-1:0] HEX_S3   = {7'h40, 7'h0E, 7'h08, 7'h00, 7'h79, 7'h40};
  localparam logic [7*N-1:0] HEX_S4   = {7'h40, 7'h30, 7'h08, 7'h00, 7'h79, 7'h0E};
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_blank = 1'b0;
  logic refresh_req = 1'b0;
  logic [2:0] wr_digit = 3'd0;
  logic [3:0] wr_value = 4'h0;
  logic wr_ready, busy;
  logic [7*N-1:0] hex_out;

  hex_display_sequencer #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_digit(wr_digit), .wr_value(wr_value), .wr_blank(wr_blank),
    .refresh_req(refresh_req), .busy(busy), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Model: sweep_left counts digits still to refresh; "want" means a sweep is owed
  logic [3:0] m_val [8];
  logic       m_blank [8];
  logic [6:0] m_hex [8];
  int         m_left;
  bit         m_want;
  int         m_edges;
  bit         mdl_acc, mdl_wrap, mdl_ok;
  int         mdl_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_val[i] = 4'h0;
        m_blank[i] = 1'b1;
        m_hex[i] = 7'h7F;
      end
      m_left = 0;
      m_want = 1'b0;
      m_edges = 0;
    end else begin
      mdl_acc = wr_valid && (m_left == 0);
      mdl_ok = mdl_acc && (32'(wr_digit) < N);
      if (mdl_ok) begin
        m_val[wr_digit] = wr_value;
        m_blank[wr_digit] = wr_blank;
      end
      mdl_wrap = ((m_edges + 1) % R) == 0;
      m_edges++;
      if (m_left > 0) begin
        mdl_d = int'(N) - m_left;
        m_hex[mdl_d] = m_blank[mdl_d] ? 7'h7F : SEG[m_val[mdl_d]];
        m_left--;
        m_want = m_want | mdl_wrap | refresh_req;
      end else if (m_want || refresh_req) begin
        m_left = int'(N);
        m_want = 1'b0;
      end else begin
        m_want = mdl_ok || mdl_wrap;
      end
    end
  end

  function automatic logic [7*N-1:0] exp_hex();
    logic [7*N-1:0] r;
    for (int k = 0; k < int'(N); k++) r[7*k +: 7] = m_hex[k];
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("wr_ready", 64'(wr_ready), 64'(m_left == 0));
      chk("hex_out", 64'(hex_out), 64'(exp_hex()));
    end
  end

  // Sweep monitor: number of sweeps started and length of the last one
  int   runs = 0;
  int   cur_len = 0;
  int   last_len = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    prev_busy <= busy;
    cur_len <= busy ? cur_len + 1 : 0;
    if (busy && !prev_busy) runs <= runs + 1;
    if (!busy && prev_busy) last_len <= cur_len;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] d, input logic [3:0] v, input logic b, output int n);
    wr_digit = d;
    wr_value = v;
    wr_blank = b;
    wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("write_wait_bound", 64'(n < 50), 64'(1));
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int idle_n = 0;
    int guard = 0;
    while (idle_n < 3 && guard < 400) begin
      @(negedge clk);
      guard++;
      idle_n = busy ? 0 : idle_n + 1;
    end
    chk("quiet_bound", 64'(guard < 400), 64'(1));
  endtask

  task automatic wait_busy();
    int guard = 0;
    while (!busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_bound", 64'(guard < 50), 64'(1));
  endtask

  task automatic align(input int off);
    int guard = 0;
    while (((m_edges + 1) % R) != off && guard < R + 5) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    int n, cnt, r0;
    logic [3:0] vals [6];
    vals = '{4'h0, 4'h1, 4'h8, 4'hA, 4'hF, 4'h0};

    // Reset and first periodic sweep with all digits blank
    cyc(3);
    #1;
    chk("rst_hex", 64'(hex_out), 64'(ALL_OFF));
    chk("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(wr_ready), 64'(1));
    cnt = 0;
    while (!busy && cnt < R + 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("first_sweep_delay", 64'(cnt), 64'(R + 1));
    wait_quiet();
    chk("s1_hex_blank", 64'(hex_out), 64'(ALL_OFF));

    // Single write drives one six-cycle sweep
    align(10);
    r0 = runs;
    do_write(3'd2, 4'h8, 1'b0, n);
    cyc(4);
    chk("s2_digit2", 64'(hex_out[20:14]), 64'(7'h00));
    wait_quiet();
    chk("s2_busy_len", 64'(last_len), 64'(6));
    chk("s2_sweeps", 64'(runs - r0), 64'(1));
    chk("s2_hex", 64'(hex_out), 64'(HEX_ONE8));

    // Back-to-back writes of all digits
    align(10);
    for (int i = 0; i < 6; i++) do_write(3'(i), vals[i], 1'b0, n);
    wait_quiet();
    chk("s3_hex", 64'(hex_out), 64'(HEX_S3));

    // Write stalled during a sweep triggers a second sweep
    align(10);
    r0 = runs;
    do_write(3'd0, 4'hF, 1'b0, n);
    wait_busy();
    wr_valid = 1'b1;
    #1;
    chk("s4_ready_low", 64'(wr_ready), 64'(0));
    do_write(3'd4, 4'h3, 1'b0, n);
    chk("s4_stall_cycles", 64'(n), 64'(6));
    wait_quiet();
    chk("s4_sweeps", 64'(runs - r0), 64'(2));
    chk("s4_hex", 64'(hex_out), 64'(HEX_S4));

    // refresh_req mid-sweep yields exactly one extra sweep
    align(10);
    r0 = runs;
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    wait_busy();
    cyc(2);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    wait_quiet();
    chk("s4_refresh_sweeps", 64'(runs - r0), 64'(2));

    // Out-of-range digit is acknowledged and ignored
    align(10);
    r0 = runs;
    do_write(3'd7, 4'h8, 1'b0, n);
    chk("s5_bad_digit_ack", 64'(n), 64'(0));
    cyc(20);
    chk("s5_bad_digit_nosweep", 64'(runs - r0), 64'(0));
    chk("s5_bad_digit_hex", 64'(hex_out), 64'(HEX_S4));

    // Write landing on the divider wrap edge gives one sweep with the new value
    align(0);
    r0 = runs;
    do_write(3'd5, 4'h1, 1'b0, n);
    chk("s5_wrap_ack", 64'(n), 64'(0));
    wait_quiet();
    chk("s5_wrap_sweeps", 64'(runs - r0), 64'(1));
    chk("s5_wrap_digit5", 64'(hex_out[41:35]), 64'(7'h79));

    // Reset in the middle of a sweep
    align(10);
    do_write(3'd3, 4'h0, 1'b0, n);
    wait_busy();
    cyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_hex", 64'(hex_out), 64'(ALL_OFF));
    chk("s6_rst_busy", 64'(busy), 64'(0));
    cyc(2);
    rst_n = 1'b1;
    #1;
    chk("s6_ready", 64'(wr_ready), 64'(1));
    @(negedge clk);
    do_write(3'd2, 4'h8, 1'b0, n);
    cyc(4);
    chk("s6_digit2", 64'(hex_out[20:14]), 64'(7'h00));
    wait_quiet();
    chk("s6_busy_len", 64'(last_len), 64'(6));
    chk("s6_hex", 64'(hex_out), 64'(HEX_ONE8));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
